// File: rtl/mux_scan.sv
`default_nettype none
// =============================================================================
// Module      : mux_scan
// Description : NUM_CH:1 channel selector with registered output and a
//               built-in scan sequencer (manual / masked round-robin scan).
// Revision    : 1.0 - initial release
// =============================================================================
module mux_scan #(
   parameter int NUM_CH  = 16,
   parameter int DATA_W  = 1,
   parameter int DWELL_W = 8,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] a,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     start,
   input  logic                     stop,
   input  logic [NUM_CH-1:0]        en_mask,
   input  logic [DWELL_W-1:0]       dwell,
   output logic [DATA_W-1:0]        y,
   output logic [SEL_W-1:0]         ch,
   output logic                     y_valid,
   output logic                     wrap,
   output logic                     busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2
   } state_t;

   localparam logic [SEL_W:0] c_num_ch = (SEL_W+1)'(NUM_CH);

   state_t              r_state;
   logic [DATA_W-1:0]   r_y;
   logic [SEL_W-1:0]    r_ch;
   logic                r_valid;
   logic                r_wrap;
   logic [DWELL_W-1:0]  r_cnt;

   logic [SEL_W-1:0]    w_first;
   logic [SEL_W-1:0]    w_next;
   logic                w_sel_ok;
   logic [DATA_W-1:0]   w_a_sel;
   logic [DATA_W-1:0]   w_a_ch;
   logic [DATA_W-1:0]   w_a_first;
   logic [DATA_W-1:0]   w_a_next;

   // Out-of-range indices return zero, which is exactly what manual mode needs.
   function automatic logic [DATA_W-1:0] pick(
      input logic [NUM_CH*DATA_W-1:0] vec,
      input logic [SEL_W-1:0]         k
   );
      logic [DATA_W-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (k == SEL_W'(i)) v = vec[i*DATA_W +: DATA_W];
      end
      return v;
   endfunction

   // Lowest enabled channel, and the next enabled one strictly after r_ch
   // (circular); descending loops let the nearest candidate win.
   always_comb begin
      int idx;
      idx     = 0;
      w_first = '0;
      for (int i = NUM_CH-1; i >= 0; i--) begin
         if (en_mask[i]) w_first = SEL_W'(i);
      end
      w_next = r_ch;
      for (int i = NUM_CH; i >= 1; i--) begin
         idx = int'(r_ch) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (en_mask[SEL_W'(idx)]) w_next = SEL_W'(idx);
      end
   end

   assign w_sel_ok  = ({1'b0, sel} < c_num_ch);
   assign w_a_sel   = pick(a, sel);
   assign w_a_ch    = pick(a, r_ch);
   assign w_a_first = pick(a, w_first);
   assign w_a_next  = pick(a, w_next);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_y     <= '0;
         r_ch    <= '0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_wrap <= 1'b0;
         // mode=0 wins from every state and always performs a manual load.
         if (!mode) begin
            r_state <= MANUAL;
            if (w_sel_ok) begin
               r_ch    <= sel;
               r_y     <= w_a_sel;
               r_valid <= 1'b1;
            end else begin
               r_y     <= '0;
               r_valid <= 1'b0;
            end
         end else begin
            case (r_state)
               IDLE: begin
                  if (start && (|en_mask)) begin
                     r_state <= SCAN;
                     r_ch    <= w_first;
                     r_y     <= w_a_first;
                     r_cnt   <= dwell;
                     r_valid <= 1'b1;
                  end else begin
                     r_valid <= 1'b0;
                  end
               end
               MANUAL: begin
                  r_state <= IDLE;
                  r_valid <= 1'b0;
               end
               SCAN: begin
                  if (stop || !(|en_mask)) begin
                     r_state <= IDLE;
                     r_valid <= 1'b0;
                  end else if (r_cnt != '0) begin
                     r_cnt   <= r_cnt - DWELL_W'(1);
                     r_y     <= w_a_ch;
                     r_valid <= 1'b1;
                  end else begin
                     r_ch    <= w_next;
                     r_y     <= w_a_next;
                     r_cnt   <= dwell;
                     r_valid <= 1'b1;
                     r_wrap  <= (w_next <= r_ch);
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign y       = r_y;
   assign ch      = r_ch;
   assign y_valid = r_valid;
   assign wrap    = r_wrap;
   assign busy    = (r_state == SCAN);

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// =============================================================================
// Module      : tb_mux_scan
// Description : Self-checking bench for mux_scan (behavioural model + literals).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_mux_scan;

   localparam int N  = 16;
   localparam int DW = 4;
   localparam int KW = 8;
   localparam int SW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [N*DW-1:0] a;
   logic            mode, start, stop;
   logic [SW-1:0]   sel;
   logic [N-1:0]    en_mask;
   logic [KW-1:0]   dwell;
   logic [DW-1:0]   y;
   logic [SW-1:0]   ch;
   logic            y_valid, wrap, busy;

   logic [12*DW-1:0] a12;
   logic [3:0]       sel12;
   logic [11:0]      mask12;
   logic [KW-1:0]    dwell12;
   logic [DW-1:0]    y12;
   logic [3:0]       ch12;
   logic             v12, wrap12, busy12;

   mux_scan #(.NUM_CH(N), .DATA_W(DW), .DWELL_W(KW)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .mode(mode), .sel(sel),
      .start(start), .stop(stop), .en_mask(en_mask), .dwell(dwell),
      .y(y), .ch(ch), .y_valid(y_valid), .wrap(wrap), .busy(busy)
   );

   mux_scan #(.NUM_CH(12), .DATA_W(DW), .DWELL_W(KW)) dut12 (
      .clk(clk), .rst_n(rst_n), .a(a12), .mode(1'b0), .sel(sel12),
      .start(1'b0), .stop(1'b0), .en_mask(mask12), .dwell(dwell12),
      .y(y12), .ch(ch12), .y_valid(v12), .wrap(wrap12), .busy(busy12)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: channel shown for (hold+1) cycles, then the next
   // enabled channel found by a circular search.
   localparam int M_IDLE = 0, M_MAN = 1, M_SCAN = 2;
   int            m_st = M_IDLE, m_ch = 0, m_shown = 0, m_hold = 0;
   logic [DW-1:0] m_y = '0;
   bit            m_valid = 1'b0, m_wrap = 1'b0;

   function automatic logic [DW-1:0] chan(input int k);
      return a[k*DW +: DW];
   endfunction

   function automatic int next_on(input int from);
      for (int i = 1; i <= N; i++) begin
         int k;
         k = ((from + i) % N + N) % N;
         if (en_mask[k]) return k;
      end
      return from;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st = M_IDLE; m_ch = 0; m_y = '0; m_valid = 0; m_wrap = 0;
         m_shown = 0; m_hold = 0;
      end else begin
         m_wrap = 0;
         if (!mode) begin
            m_st = M_MAN;
            if (int'(sel) < N) begin
               m_ch = int'(sel); m_y = chan(m_ch); m_valid = 1;
            end else begin
               m_y = '0; m_valid = 0;
            end
         end else if (m_st == M_IDLE) begin
            if (start && en_mask != '0) begin
               m_st = M_SCAN; m_ch = next_on(-1); m_y = chan(m_ch);
               m_valid = 1; m_shown = 1; m_hold = int'(dwell);
            end else begin
               m_valid = 0;
            end
         end else if (m_st == M_MAN) begin
            m_st = M_IDLE; m_valid = 0;
         end else begin
            if (stop || en_mask == '0) begin
               m_st = M_IDLE; m_valid = 0;
            end else if (m_shown < m_hold + 1) begin
               m_shown++; m_y = chan(m_ch); m_valid = 1;
            end else begin
               int nxt;
               nxt = next_on(m_ch);
               m_wrap = (nxt <= m_ch);
               m_ch = nxt; m_y = chan(m_ch); m_valid = 1;
               m_shown = 1; m_hold = int'(dwell);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_y",       y,       m_y);
         chk("cyc_ch",      ch,      m_ch);
         chk("cyc_y_valid", y_valid, m_valid);
         chk("cyc_wrap",    wrap,    m_wrap);
         chk("cyc_busy",    busy,    (m_st == M_SCAN));
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_ch[9] = '{0, 0, 5, 5, 10, 10, 15, 15, 0};
      int s3[3]     = '{3, 12, 7};
      logic [DW-1:0] exp_v;

      rst_n = 1'b0; a = '0; mode = 1'b1; start = 1'b0; stop = 1'b0;
      sel = '0; en_mask = '0; dwell = '0;
      a12 = '0; sel12 = '0; mask12 = '0; dwell12 = '0;
      repeat (3) @(negedge clk);
      chk("rst_y", y, 0); chk("rst_ch", ch, 0); chk("rst_valid", y_valid, 0);
      chk("rst_wrap", wrap, 0); chk("rst_busy", busy, 0);
      chk_en = 1'b1;
      rst_n  = 1'b1;

      // Manual sweep, a[k] = k[0]
      mode = 1'b0;
      for (int k = 0; k < N; k++) a[k*DW +: DW] = DW'(k & 1);
      for (int s = 0; s < N; s++) begin
         sel = SW'(s);
         @(negedge clk);
         chk("man_y", y, s & 1); chk("man_ch", ch, s); chk("man_valid", y_valid, 1);
      end
      // Second pattern, a[k] = 15-k
      for (int k = 0; k < N; k++) a[k*DW +: DW] = DW'(15 - k);
      for (int i = 0; i < 3; i++) begin
         sel = SW'(s3[i]);
         @(negedge clk);
         chk("man2_y", y, 15 - s3[i]); chk("man2_ch", ch, s3[i]);
      end

      // 12-channel instance: out-of-range select
      for (int k = 0; k < 12; k++) a12[k*DW +: DW] = DW'(k + 1);
      sel12 = 4'd5;  @(negedge clk);
      chk("m12_y", y12, 6); chk("m12_ch", ch12, 5); chk("m12_valid", v12, 1);
      sel12 = 4'd13; @(negedge clk);
      chk("m12_oor_y", y12, 0); chk("m12_oor_ch", ch12, 5); chk("m12_oor_valid", v12, 0);
      sel12 = 4'd11; @(negedge clk);
      chk("m12_top_y", y12, 12); chk("m12_top_ch", ch12, 11); chk("m12_top_valid", v12, 1);

      // Masked scan
      mode = 1'b1;
      @(negedge clk);
      chk("idle_valid", y_valid, 0); chk("idle_busy", busy, 0);
      for (int k = 0; k < N; k++) a[k*DW +: DW] = DW'(k + 3);
      en_mask = 16'h8421; dwell = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         chk("scan_ch", ch, exp_ch[i]);
         chk("scan_y", y, (exp_ch[i] + 3) & 15);
         chk("scan_wrap", wrap, (i == 8));
         chk("scan_busy", busy, 1);
         chk("model_ch", m_ch, exp_ch[i]);
      end

      // Stop from SCAN
      stop = 1'b1; @(negedge clk); stop = 1'b0;
      chk("stop_valid", y_valid, 0); chk("stop_busy", busy, 0);

      // Single channel, dwell 0
      en_mask = 16'h0010; dwell = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("single_ch", ch, 4); chk("single_wrap", wrap, (i > 0));
      end
      stop = 1'b1; @(negedge clk); stop = 1'b0;

      // Live tracking and mid-dwell mask change
      en_mask = 16'h0024; dwell = 8'd3; start = 1'b1;
      exp_v = 4'h3; a[2*DW +: DW] = exp_v;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         chk("live_ch", ch, 2); chk("live_y", y, exp_v);
         exp_v = exp_v ^ 4'hF;
         a[2*DW +: DW] = exp_v;
         if (i == 0) en_mask = 16'h0020;
      end
      @(negedge clk);
      chk("live_next_ch", ch, 5); chk("live_next_y", y, 8); chk("live_next_wrap", wrap, 0);

      // Aborts
      stop = 1'b1; @(negedge clk); stop = 1'b0;
      chk("abort_stop_valid", y_valid, 0); chk("abort_stop_busy", busy, 0);
      start = 1'b1; @(negedge clk); start = 1'b0;
      chk("restart_busy", busy, 1); chk("restart_ch", ch, 5);
      mode = 1'b0; sel = 4'd9; @(negedge clk);
      chk("abort_man_ch", ch, 9); chk("abort_man_y", y, 12);
      chk("abort_man_valid", y_valid, 1); chk("abort_man_busy", busy, 0);
      mode = 1'b1; @(negedge clk);
      en_mask = 16'hFFFF; dwell = 8'd2; start = 1'b1; @(negedge clk); start = 1'b0;
      chk("mask_scan_busy", busy, 1);
      en_mask = 16'h0000; @(negedge clk);
      chk("mask0_busy", busy, 0); chk("mask0_valid", y_valid, 0);

      // Asynchronous reset mid-scan
      en_mask = 16'hFFFF; dwell = 8'd2; start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_y", y, 0); chk("arst_ch", ch, 0); chk("arst_valid", y_valid, 0);
      chk("arst_wrap", wrap, 0); chk("arst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux_scan.md
# mux_scan

Parametrised NUM_CH:1 channel selector with registered output and built-in channel sequencer. It replaces hand-built mux trees in the structure library.
- Manual mode: routes the externally selected channel.
- Scan mode: autonomously steps through a masked subset of channels, holding each for a programmable dwell time.
- Sits between multi-channel data sources and single-lane consumers: monitors, serialisers, test observers.

## Interface
- NUM_CH, 16, number of input channels (≥2).
- DATA_W, 1, width of each channel in bits.
- DWELL_W, 8, width of dwell count.
- SEL_W (localparam), $clog2(NUM_CH), channel index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- a  in  NUM_CH*DATA_W  packed channels; channel k = a[k*DATA_W +: DATA_W].
- mode  in  1  0 = manual, 1 = scan.
- sel  in  SEL_W  manual channel index.
- start  in  1  scan start pulse (used in IDLE only).
- stop  in  1  scan abort (used in SCAN only).
- en_mask  in  NUM_CH  channels eligible for scan; bit k enables channel k.
- dwell  in  DWELL_W  extra cycles per channel; hold = dwell+1 cycles.
- y  out  DATA_W  registered selected data.
- ch  out  SEL_W  channel index that y was taken from.
- y_valid  out  1  y/ch hold a legal selection.
- wrap  out  1  one-cycle pulse when scan wraps.
- busy  out  1  high while in SCAN.

## Operation
- States: IDLE, MANUAL, SCAN.
- Reset: state IDLE; y=0, ch=0, y_valid=0, wrap=0, busy=0; dwell counter 0.
- Coherency: y and ch are registers loaded on the same edge. y = a[ch] sampled at that edge.
- IDLE:
  - mode=0 → MANUAL, loading from sel on that edge.
  - mode=1 & start & |en_mask → SCAN. Load ch = lowest enabled index and y = a[that index]. Load counter = dwell.
  - Otherwise stay; y and ch hold; y_valid=0.
- MANUAL, every edge:
  - mode=1 → IDLE. y and ch hold; y_valid=0.
  - Otherwise, if sel < NUM_CH: ch←sel, y←a[sel], y_valid=1.
  - Otherwise (sel ≥ NUM_CH, possible when NUM_CH is not a power of 2): y←0, ch holds, y_valid=0.
- SCAN priority per edge, highest first:
  1. mode=0 → MANUAL, loading from sel as above.
  2. stop → IDLE; y_valid=0.
  3. en_mask==0 → IDLE; y_valid=0.
  4. counter≠0 → decrement. ch holds; y←a[ch], tracking live data; y_valid=1.
  5. counter==0 → advance. ch←next enabled index strictly after ch, circular. Counter←dwell (current input value). y←a[new ch].
- Advance rules:
  - If the only enabled channel is ch itself, ch stays and counter reloads.
  - wrap=1 for exactly the cycle after an advance where new index ≤ old index, including the single-channel self-advance. wrap=0 otherwise.
- Mask and dwell changes:
  - en_mask is evaluated at advance time only. Disabling the current channel mid-dwell does not cut its dwell short.
  - A dwell change takes effect at the next counter load.
- start outside IDLE and stop outside SCAN are ignored.
- busy = (state==SCAN).
- Reset assertion in any state forces the reset values immediately, without waiting for clk. The first post-reset edge behaves as IDLE.

## Timing
- Latency a→y: 1 cycle in all modes. y is never combinational from a.
- Manual: sel change at edge n → ch/y valid after edge n.
- Scan entry: start sampled at edge n → first channel on outputs after edge n, busy=1 after edge n.
- Each channel is presented for exactly dwell+1 consecutive cycles.
- Full cycle through M enabled channels = M·(dwell+1) cycles. wrap asserts once per cycle.
- Exit to IDLE/MANUAL takes effect at the sampling edge. No drain cycles.

## Test plan
- Reset mid-scan: NUM_CH=16, mask=16'hFFFF, dwell=2, start; assert rst_n low at cycle 7 → all outputs 0 asynchronously, state IDLE, busy=0.
- Manual sweep: mode=0; sel 0..15 with a[k]=k[0] pattern → y matches a[sel] one cycle later with y_valid=1. For NUM_CH=12, sel=13 → y=0, y_valid=0.
- Masked scan: mask=16'h8421, dwell=1 → ch sequence 0,0,5,5,10,10,15,15,0. wrap high only the cycle ch returns to 0. busy=1 throughout.
- Single channel: mask=16'h0010, dwell=0 → ch=4 every cycle, wrap=1 every cycle after the first.
- Live tracking and mask change: dwell=3 on ch 2; toggle a[2] each cycle → y follows with 1-cycle lag. Clear mask bit 2 mid-dwell → ch 2 still held 4 cycles, then the next enabled channel.
- Aborts: in SCAN assert stop → IDLE, y_valid=0. Restart, then drop mode to 0 with sel=9 → MANUAL, ch=9 next cycle. Mask→0 during SCAN → IDLE next cycle.
